// File: rtl/imm_encoder_if.sv
// ============================================================================
// imm_encoder_if : request/result bundle between a requester and imm_encoder
// Revision 1.0
// ============================================================================
`default_nettype none

interface imm_encoder_if;
  logic        Start;
  logic [1:0]  ImmSrc;
  logic [31:0] Value;
  logic        Busy;
  logic        Done;
  logic        Valid;
  logic [23:0] Instr;

  modport master (
    output Start, ImmSrc, Value,
    input  Busy, Done, Valid, Instr
  );

  modport slave (
    input  Start, ImmSrc, Value,
    output Busy, Done, Valid, Instr
  );
endinterface

`default_nettype wire

// File: rtl/imm_encoder.sv
// ============================================================================
// imm_encoder : 32-bit constant/offset -> 24-bit ARM immediate field encoder
// Revision 1.0
// ============================================================================
`default_nettype none

module imm_encoder (
  input  wire logic       clk,
  input  wire logic       reset,
  imm_encoder_if.slave    bus_if
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  rot_q, rot_d;
  logic [31:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic [23:0] instr_q, instr_d;

  // Rotate left by 2*rot: the upper half of the doubled word shifted left.
  logic [5:0]  w_shamt;
  logic [63:0] w_dbl;
  logic [31:0] w_rol;
  assign w_shamt = {1'b0, rot_q, 1'b0};
  assign w_dbl   = {value_q, value_q} << w_shamt;
  assign w_rol   = w_dbl[63:32];

  logic w_br_ok;
  assign w_br_ok = (bus_if.Value[1:0] == 2'b00) &&
                   (bus_if.Value[31:25] == {7{bus_if.Value[25]}});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rot_q   <= 4'd0;
      value_q <= 32'd0;
      valid_q <= 1'b0;
      instr_q <= 24'd0;
    end else begin
      state_q <= state_d;
      rot_q   <= rot_d;
      value_q <= value_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rot_d   = rot_q;
    value_d = value_q;
    valid_d = valid_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: begin
        if (bus_if.Start) begin
          value_d = bus_if.Value;
          rot_d   = 4'd0;
          valid_d = 1'b0;
          instr_d = 24'd0;
          state_d = S_DONE;
          case (bus_if.ImmSrc)
            2'b00: state_d = S_SEARCH;
            2'b01: begin
              if (bus_if.Value[31:12] == 20'd0) begin
                valid_d = 1'b1;
                instr_d = {12'd0, bus_if.Value[11:0]};
              end
            end
            2'b10: begin
              if (w_br_ok) begin
                valid_d = 1'b1;
                instr_d = bus_if.Value[25:2];
              end
            end
            default: ;
          endcase
        end
      end
      S_SEARCH: begin
        if (w_rol[31:8] == 24'd0) begin
          valid_d = 1'b1;
          instr_d = {12'd0, rot_q, w_rol[7:0]};
          state_d = S_DONE;
        end else if (rot_q == 4'd15) begin
          state_d = S_DONE;
        end else begin
          rot_d = rot_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus_if.Busy  = (state_q != S_IDLE);
  assign bus_if.Done  = (state_q == S_DONE);
  assign bus_if.Valid = valid_q;
  assign bus_if.Instr = instr_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_encoder.sv
// ============================================================================
// tb_imm_encoder : directed + randomized checks of imm_encoder against a model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_imm_encoder;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  imm_encoder_if bus ();

  imm_encoder dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: search rotations arithmetically; latency counted in cycles after the Start edge.
  task automatic ref_enc(input logic [1:0] src, input logic [31:0] v,
                         output logic ok, output logic [23:0] ins, output int lat);
    logic [31:0] rv;
    longint sv;
    ok = 1'b0; ins = 24'd0; lat = 1;
    case (src)
      2'b00: begin
        lat = 17;
        for (int r = 0; r < 16; r++) begin
          rv = (r == 0) ? v : ((v << (2 * r)) | (v >> (32 - 2 * r)));
          if (!ok && rv < 32'd256) begin
            ok = 1'b1; ins = 24'(r * 256 + rv); lat = r + 2;
          end
        end
      end
      2'b01: if (v < 32'd4096) begin ok = 1'b1; ins = v[23:0]; end
      2'b10: begin
        sv = longint'($signed(v));
        if ((v % 4 == 0) && sv >= -(64'sd1 << 25) && sv < (64'sd1 << 25)) begin
          ok = 1'b1; ins = 24'((v >> 2) & 32'hFFFFFF);
        end
      end
      default: ;
    endcase
  endtask

  // Drives one request at the current negedge; returns at the negedge one cycle after Done.
  task automatic run(input string tag, input logic [1:0] src, input logic [31:0] v);
    logic ok; logic [23:0] ins; int lat; int cyc;
    ref_enc(src, v, ok, ins, lat);
    bus.Start = 1'b1; bus.ImmSrc = src; bus.Value = v;
    @(negedge clk);
    cyc = 1;
    bus.Start = 1'b0;
    bus.Value = ~v;
    bus.ImmSrc = ~src;
    while (!bus.Done && cyc < 40) begin
      chk({tag, "_busy"}, 32'(bus.Busy), 32'd1);
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(lat));
    chk({tag, "_busy_done"}, 32'(bus.Busy), 32'd1);
    chk({tag, "_valid"}, 32'(bus.Valid), 32'(ok));
    chk({tag, "_instr"}, 32'(bus.Instr), 32'(ins));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(bus.Done), 32'd0);
    chk({tag, "_idle"}, 32'(bus.Busy), 32'd0);
    chk({tag, "_hold"}, {7'd0, bus.Valid, bus.Instr}, {7'd0, ok, ins});
  endtask

  initial begin
    int dones;
    logic [31:0] v;
    logic [1:0]  s;
    checks = 0; failures = 0;
    reset = 1'b1; bus.Start = 1'b0; bus.ImmSrc = 2'b00; bus.Value = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy",  32'(bus.Busy),  32'd0);
    chk("rst_done",  32'(bus.Done),  32'd0);
    chk("rst_valid", 32'(bus.Valid), 32'd0);
    chk("rst_instr", 32'(bus.Instr), 32'd0);

    run("dp_ff",      2'b00, 32'h000000FF);
    run("dp_ff000000",2'b00, 32'hFF000000);
    run("dp_zero",    2'b00, 32'h00000000);
    run("dp_wrap",    2'b00, 32'hF000000F);
    run("u12_abc",    2'b01, 32'h00000ABC);
    run("u12_1000",   2'b01, 32'h00001000);
    run("br_neg",     2'b10, 32'hFFFFFFF8);
    run("br_mis",     2'b10, 32'h00000006);
    run("br_oor",     2'b10, 32'h02000000);
    run("br_max",     2'b10, 32'h01FFFFFC);
    run("br_min",     2'b10, 32'hFE000000);
    run("rsvd",       2'b11, 32'h00000004);

    // Unencodable search with a second Start mid-search that must be ignored.
    bus.Start = 1'b1; bus.ImmSrc = 2'b00; bus.Value = 32'h00000101;
    dones = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.Start = (c == 8);
      bus.ImmSrc = (c == 8) ? 2'b01 : 2'b00;
      bus.Value = (c == 8) ? 32'h00000007 : 32'h00000101;
      if (bus.Done) begin
        dones++;
        chk("nomatch_lat", 32'(c), 32'd17);
        chk("nomatch_valid", 32'(bus.Valid), 32'd0);
        chk("nomatch_instr", 32'(bus.Instr), 32'd0);
      end
    end
    chk("nomatch_dones", 32'(dones), 32'd1);
    chk("nomatch_idle", 32'(bus.Busy), 32'd0);

    // Reset during search aborts without Done; a new request follows immediately.
    run("pre_rst", 2'b01, 32'h00000123);
    bus.Start = 1'b1; bus.ImmSrc = 2'b00; bus.Value = 32'h00000101;
    dones = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.Start = 1'b0;
      if (bus.Done) dones++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy",  32'(bus.Busy),  32'd0);
    chk("abort_done",  32'(bus.Done | (dones != 0)), 32'd0);
    chk("abort_valid", 32'(bus.Valid), 32'd0);
    chk("abort_instr", 32'(bus.Instr), 32'd0);
    run("post_rst", 2'b01, 32'h00000005);

    // Randomized requests, issued back-to-back in the cycle after each Done.
    for (int i = 0; i < 60; i++) begin
      s = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: v = $urandom;
        1: begin
          v = 32'($urandom_range(0, 255));
          for (int k = 0; k < int'($urandom_range(0, 15)); k++) v = {v[1:0], v[31:2]};
        end
        default: v = (s == 2'b10) ? ($urandom & 32'h03FFFFFC) | ({32{v[0]}} & 32'hFC000000)
                                  : 32'($urandom_range(0, 8191));
      endcase
      run("rand", s, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate extend unit: takes a 32-bit constant or branch offset and produces the 24-bit instruction immediate field for the selected ImmSrc format, or flags it as unencodable.
- Used by the self-test/program-loader path to build instruction words on chip.
- The data-processing (rotated imm8) search is iterative, testing one rotation per cycle.
- Start/Busy/Done handshake toward the requester.

Parameters:
- None. ARM field widths are fixed: imm8, rot4, imm12, imm24.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- Start  input  1  request; sampled only when Busy=0
- ImmSrc  input  2  format: 00 rotated imm8, 01 unsigned imm12, 10 branch imm24, 11 reserved
- Value  input  32  constant (00/01) or byte offset (10)
- Busy  output  1  high while the block is not IDLE
- Done  output  1  one-cycle pulse when the result is valid
- Valid  output  1  Value is encodable in the requested format
- Instr  output  24  encoded field; zero-filled above the field; all zero when Valid=0

Behaviour:
- Reset (synchronous): state IDLE, rotation counter 0; Busy, Done, Valid and Instr all 0. Reset mid-SEARCH aborts the request with no Done pulse.
- States:
  - IDLE: Start=1 captures Value and ImmSrc into internal registers. Go to SEARCH if ImmSrc=00, otherwise go to DONE.
  - SEARCH: each cycle tests rotation r (0..15). Match when ROL(Value, 2r)[31:8]==0. On match, Instr={12'b0, r[3:0], ROL(Value,2r)[7:0]}, Valid=1, go to DONE. On no match with r==15, Valid=0, Instr=0, go to DONE. Otherwise r<=r+1.
  - DONE: Done=1 for exactly this cycle, then go to IDLE.
- The smallest matching r always wins. Value=0 encodes as r=0, imm8=0.
- Single-cycle formats, evaluated on the capture edge:
  - 01: Valid=(Value[31:12]==0); Instr={12'b0, Value[11:0]}.
  - 10: Valid=(Value[1:0]==0) and Value[31:25] all equal to Value[25]; Instr=Value[25:2].
  - 11: Valid=0, Instr=0.
- Latency, with Start sampled at edge 0:
  - Formats 01/10/11: Done high in cycle 1.
  - Format 00, match at rotation k: Done high in cycle k+2.
  - Format 00, no match: Done high in cycle 17.
- Start is ignored while Busy=1; no queuing. Captured Value/ImmSrc are immune to input changes after capture.
- Valid/Instr hold their last result from Done until the next accepted Start. The new Start clears them on the capture edge.
- Start may be asserted in the cycle right after Done, since the block is back in IDLE.
- Round-trip rule: for ImmSrc 01/10 with Valid=1, feeding Instr through extend with the same ImmSrc must reproduce Value. For ImmSrc 00, this holds whenever rot=0.

Test Plan:
- ImmSrc=00, Value=0x000000FF -> Done in cycle 2, Valid=1, Instr=0x0000FF. Busy high in cycles 1-2.
- ImmSrc=00, Value=0xFF000000 -> Done in cycle 6, Valid=1, Instr=0x0004FF (rot=4).
- ImmSrc=00, Value=0x00000101 -> Done in cycle 17, Valid=0, Instr=0. A second Start at cycle 8 is ignored, with no extra Done.
- ImmSrc=01: Value=0x00000ABC -> Done in cycle 1, Valid=1, Instr=0x000ABC. Value=0x00001000 -> Valid=0, Instr=0.
- ImmSrc=10:
  - 0xFFFFFFF8 -> Valid=1, Instr=0xFFFFFE.
  - 0x00000006 -> Valid=0 (misaligned).
  - 0x02000000 -> Valid=0 (out of range).
  - 0x01FFFFFC -> Valid=1, Instr=0x7FFFFF.
- ImmSrc=00, Value=0x00000101, reset asserted in cycle 5 for 1 cycle -> Busy=0 and Valid=Instr=0 in cycle 6, no Done. A new Start in cycle 6 with ImmSrc=01, Value=0x5 -> Done in cycle 7, Instr=0x000005.
